// File: rtl/cpu_defs.sv
// Shared CPU definitions: datapath widths, register count and the GRF write-port
// arbiter state encoding.
package cpu_defs;

    localparam int DATA_W   = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef enum logic {
        PRIO_A  = 1'b0,
        FORCE_B = 1'b1
    } arb_state_t;

endpackage

// File: rtl/grf_wport_arbiter_scoreboard.sv
// Busy scoreboard for MDU results in flight: issue sets a bit, the B-port grant
// clears it, and a set wins over a clear to the same register in the same cycle.
module grf_scoreboard
    import cpu_defs::NUM_REGS;
#(
    parameter int REG_AW = cpu_defs::REG_AW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                iss_valid,
    input  logic [REG_AW-1:0]   iss_reg,
    input  logic                clr_en,
    input  logic [REG_AW-1:0]   clr_reg,
    output logic                iss_ready,
    output logic [NUM_REGS-1:0] busy
);

    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] busy_next;

    assign iss_ready = ~busy[iss_reg];

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        // $0 is hardwired to zero, so an issue to it never tracks a pending result.
        if (iss_valid && iss_ready && (iss_reg != '0))
            set_mask[iss_reg] = 1'b1;
        if (clr_en)
            clr_mask[clr_reg] = 1'b1;
        busy_next    = (busy & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            busy <= '0;
        else
            busy <= busy_next;
    end

endmodule

// File: rtl/grf_wport_arbiter.sv
// Arbitrates the single GRF write port between WB (port A, default priority) and
// the MDU result (port B, forced after STARVE_MAX lost cycles); registers the winner.
module grf_wport_arbiter
    import cpu_defs::NUM_REGS;
    import cpu_defs::arb_state_t;
    import cpu_defs::PRIO_A;
    import cpu_defs::FORCE_B;
#(
    parameter int DATA_W     = cpu_defs::DATA_W,
    parameter int REG_AW     = cpu_defs::REG_AW,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [REG_AW-1:0]   a_reg,
    input  logic [DATA_W-1:0]   a_data,
    input  logic [DATA_W-1:0]   a_pc,
    input  logic                b_valid,
    output logic                b_ready,
    input  logic [REG_AW-1:0]   b_reg,
    input  logic [DATA_W-1:0]   b_data,
    input  logic [DATA_W-1:0]   b_pc,
    input  logic                iss_valid,
    input  logic [REG_AW-1:0]   iss_reg,
    output logic                iss_ready,
    output logic [NUM_REGS-1:0] busy,
    output logic                w_en,
    output logic [REG_AW-1:0]   w_reg,
    output logic [DATA_W-1:0]   w_data,
    output logic [DATA_W-1:0]   w_pc,
    output logic                arb_state
);

    // Handshake: a request transfers in the cycle its valid and ready are both high;
    // ready is combinational from valid and arbiter state, and valid must not depend on ready.

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    arb_state_t    state, state_next;
    logic [CW-1:0] starve_cnt, starve_next;
    logic          grant_a, grant_b;

    assign arb_state = state;
    assign a_ready   = grant_a;
    assign b_ready   = grant_b;

    always_comb begin
        grant_a     = 1'b0;
        grant_b     = 1'b0;
        state_next  = state;
        starve_next = starve_cnt;

        case (state)
            PRIO_A: begin
                if (a_valid)
                    grant_a = 1'b1;
                else if (b_valid)
                    grant_b = 1'b1;
            end
            FORCE_B: begin
                // A withdrawn B request leaves nothing to force, so A is served again.
                if (b_valid)
                    grant_b = 1'b1;
                else if (a_valid)
                    grant_a = 1'b1;
            end
            default: ;
        endcase

        if (grant_b || !b_valid)
            starve_next = '0;
        else if (starve_cnt < STARVE_LIM)
            starve_next = starve_cnt + CW'(1);

        if (starve_next == STARVE_LIM)
            state_next = FORCE_B;
        else
            state_next = PRIO_A;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= PRIO_A;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_en   <= 1'b0;
            w_reg  <= '0;
            w_data <= '0;
            w_pc   <= '0;
        end else begin
            w_en <= grant_a | grant_b;
            if (grant_a) begin
                w_reg  <= a_reg;
                w_data <= a_data;
                w_pc   <= a_pc;
            end else if (grant_b) begin
                w_reg  <= b_reg;
                w_data <= b_data;
                w_pc   <= b_pc;
            end
        end
    end

    grf_scoreboard #(
        .REG_AW (REG_AW)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .iss_valid (iss_valid),
        .iss_reg   (iss_reg),
        .clr_en    (grant_b),
        .clr_reg   (b_reg),
        .iss_ready (iss_ready),
        .busy      (busy)
    );

endmodule

// File: tb/tb_grf_wport_arbiter.sv
// Directed bench for grf_wport_arbiter: reset, single-port writes, starvation
// forcing, scoreboard set/clear/set-wins, register 0 and mid-run reset.
module tb_grf_wport_arbiter;

    logic        clk;
    logic        reset;
    logic        a_valid, a_ready;
    logic [4:0]  a_reg;
    logic [31:0] a_data, a_pc;
    logic        b_valid, b_ready;
    logic [4:0]  b_reg;
    logic [31:0] b_data, b_pc;
    logic        iss_valid, iss_ready;
    logic [4:0]  iss_reg;
    logic [31:0] busy;
    logic        w_en;
    logic [4:0]  w_reg;
    logic [31:0] w_data, w_pc;
    logic        arb_state;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    grf_wport_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_reg     (a_reg),
        .a_data    (a_data),
        .a_pc      (a_pc),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_reg     (b_reg),
        .b_data    (b_data),
        .b_pc      (b_pc),
        .iss_valid (iss_valid),
        .iss_reg   (iss_reg),
        .iss_ready (iss_ready),
        .busy      (busy),
        .w_en      (w_en),
        .w_reg     (w_reg),
        .w_data    (w_data),
        .w_pc      (w_pc),
        .arb_state (arb_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid   = 1'b0; a_reg = '0; a_data = '0; a_pc = '0;
        b_valid   = 1'b0; b_reg = '0; b_data = '0; b_pc = '0;
        iss_valid = 1'b0; iss_reg = '0;
    endtask

    // compare the registered write against the oldest expected write data
    task automatic check_write(input string tag, input logic [4:0] exp_reg);
        logic [31:0] exp_d;
        check({tag, "_wen"}, {31'b0, w_en}, 32'd1);
        check({tag, "_wreg"}, {27'b0, w_reg}, {27'b0, exp_reg});
        if (exp_q.size() == 0) begin
            check({tag, "_qempty"}, 32'd1, 32'd0);
        end else begin
            exp_d = exp_q.pop_front();
            check({tag, "_wdata"}, w_data, exp_d);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        check("rst_wen", {31'b0, w_en}, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_wdata", w_data, 32'd0);
        check("rst_state", {31'b0, arb_state}, 32'd0);
        check("rst_bready", {31'b0, b_ready}, 32'd0);
        reset = 1'b1;
        step();

        // A only
        a_valid = 1'b1; a_reg = 5'd5; a_data = 32'h1234; a_pc = 32'h3000;
        #1;
        check("a_ready", {31'b0, a_ready}, 32'd1);
        check("a_bready", {31'b0, b_ready}, 32'd0);
        exp_q.push_back(32'h1234);
        step();
        a_valid = 1'b0;
        check_write("a_only", 5'd5);
        check("a_wpc", w_pc, 32'h3000);
        step();
        check("a_wen_drop", {31'b0, w_en}, 32'd0);
        check("a_hold", w_data, 32'h1234);

        // conflict: A wins STARVE_MAX cycles, then B is forced
        a_valid = 1'b1; a_reg = 5'd1; a_data = 32'hAAAA_0000; a_pc = 32'h100;
        b_valid = 1'b1; b_reg = 5'd9; b_data = 32'hBBBB_0000; b_pc = 32'h200;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("cf_aready%0d", i), {31'b0, a_ready}, 32'd1);
            check($sformatf("cf_bready%0d", i), {31'b0, b_ready}, 32'd0);
            exp_q.push_back(32'hAAAA_0000);
            step();
            check_write($sformatf("cf_a%0d", i), 5'd1);
        end
        #1;
        check("cf_force", {31'b0, arb_state}, 32'd1);
        check("cf_force_aready", {31'b0, a_ready}, 32'd0);
        check("cf_force_bready", {31'b0, b_ready}, 32'd1);
        exp_q.push_back(32'hBBBB_0000);
        step();
        check_write("cf_b", 5'd9);
        check("cf_back", {31'b0, arb_state}, 32'd0);
        check("cf_back_aready", {31'b0, a_ready}, 32'd1);
        idle_inputs();
        step();

        // scoreboard set and clear
        iss_valid = 1'b1; iss_reg = 5'd8;
        #1;
        check("sb_iss_ready", {31'b0, iss_ready}, 32'd1);
        step();
        iss_valid = 1'b0;
        check("sb_busy8", busy, 32'h0000_0100);
        check("sb_iss_blocked", {31'b0, iss_ready}, 32'd0);
        b_valid = 1'b1; b_reg = 5'd8; b_data = 32'h0000_0C0C;
        #1;
        check("sb_bready", {31'b0, b_ready}, 32'd1);
        exp_q.push_back(32'h0000_0C0C);
        step();
        b_valid = 1'b0;
        check("sb_clr", busy, 32'd0);
        check_write("sb_bw", 5'd8);
        step();

        // set wins over clear to the same register
        b_valid = 1'b1; b_reg = 5'd8; b_data = 32'h0000_0D0D;
        iss_valid = 1'b1; iss_reg = 5'd8;
        #1;
        check("sw_bready", {31'b0, b_ready}, 32'd1);
        check("sw_iss_ready", {31'b0, iss_ready}, 32'd1);
        exp_q.push_back(32'h0000_0D0D);
        step();
        b_valid = 1'b0; iss_valid = 1'b0;
        check("sw_busy", busy, 32'h0000_0100);
        check_write("sw_bw", 5'd8);

        // port A writing a busy register goes through and leaves busy set
        a_valid = 1'b1; a_reg = 5'd8; a_data = 32'h0000_0E0E;
        exp_q.push_back(32'h0000_0E0E);
        step();
        a_valid = 1'b0;
        check_write("ab_w", 5'd8);
        check("ab_busy", busy, 32'h0000_0100);
        b_valid = 1'b1; b_reg = 5'd8; b_data = 32'h0000_0F0F;
        exp_q.push_back(32'h0000_0F0F);
        step();
        b_valid = 1'b0;
        check_write("ab_bw", 5'd8);
        check("ab_clr", busy, 32'd0);

        // register 0
        iss_valid = 1'b1; iss_reg = 5'd0;
        step();
        iss_valid = 1'b0;
        check("r0_busy", busy, 32'd0);
        a_valid = 1'b1; a_reg = 5'd0; a_data = 32'h0000_5A5A;
        exp_q.push_back(32'h0000_5A5A);
        step();
        a_valid = 1'b0;
        check_write("r0_w", 5'd0);
        check("r0_busy2", busy, 32'd0);

        // reset mid-run with a write pending and a busy bit set
        iss_valid = 1'b1; iss_reg = 5'd7;
        a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h0000_7777;
        step();
        idle_inputs();
        check("mr_pre_wen", {31'b0, w_en}, 32'd1);
        check("mr_pre_busy", busy, 32'h0000_0080);
        reset = 1'b0;
        #1;
        check("mr_wen", {31'b0, w_en}, 32'd0);
        check("mr_busy", busy, 32'd0);
        step();
        check("mr_wen2", {31'b0, w_en}, 32'd0);
        reset = 1'b1;
        step();

        check("q_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
